// File: rtl/lc3b_types.sv
// Shared LC-3b types: word, cache line and the physical-memory arbiter state.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

endpackage

// File: rtl/pmem_arbiter_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical memory port between the instruction and data caches.
// Define PMEM_ARB_ROUND_ROBIN_EN to alternate simultaneous requests; otherwise d always wins.
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_read,
    input  logic                 i_write,
    input  lc3b_word             i_address,
    input  lc3b_cacheline        i_wdata,
    output logic                 i_resp,
    output lc3b_cacheline        i_rdata,
    input  logic                 d_read,
    input  logic                 d_write,
    input  lc3b_word             d_address,
    input  lc3b_cacheline        d_wdata,
    output logic                 d_resp,
    output lc3b_cacheline        d_rdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output lc3b_word             pmem_address,
    output lc3b_cacheline        pmem_wdata,
    input  logic                 pmem_resp,
    input  lc3b_cacheline        pmem_rdata,
    output logic [CNT_W-1:0]     i_grants,
    output logic [CNT_W-1:0]     d_grants
);

    arb_state_t state_reg, state_next;
    logic       i_pending, d_pending, d_wins;

    assign i_pending = i_read | i_write;
    assign d_pending = d_read | d_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    // Set when d was the most recent requester to complete.
    logic last_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_reg <= 1'b0;
        end else if (i_resp || d_resp) begin
            last_d_reg <= d_resp;
        end
    end

    assign d_wins = ~last_d_reg;
`else
    assign d_wins = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        i_rdata      = '0;
        d_resp       = 1'b0;
        d_rdata      = '0;
        case (state_reg)
            IDLE: begin
                // pmem_resp is deliberately ignored here.
                if (i_pending && d_pending) begin
                    state_next = d_wins ? SERVE_D : SERVE_I;
                end else if (d_pending) begin
                    state_next = SERVE_D;
                end else if (i_pending) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                // A simultaneous read+write is forwarded as the write only.
                pmem_write   = i_write;
                pmem_read    = i_read & ~i_write;
                pmem_address = i_address;
                pmem_wdata   = i_wdata;
                if (pmem_resp) begin
                    i_resp     = 1'b1;
                    i_rdata    = pmem_rdata;
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                if (pmem_resp) begin
                    d_resp     = 1'b1;
                    d_rdata    = pmem_rdata;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_i_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_resp),
        .count (i_grants)
    );

    sat_counter #(.W(CNT_W)) u_d_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_resp),
        .count (d_grants)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: random requesters and memory, a transaction-level
// reference model pushing expected grants/responses, and a monitor that pops and compares.
module tb_pmem_arbiter;
    import lc3b_types::*;

    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_read, i_write, d_read, d_write;
    lc3b_word        i_address, d_address;
    lc3b_cacheline   i_wdata, d_wdata;
    logic            i_resp, d_resp;
    lc3b_cacheline   i_rdata, d_rdata;
    logic            pmem_read, pmem_write, pmem_resp;
    lc3b_word        pmem_address;
    lc3b_cacheline   pmem_wdata, pmem_rdata;
    logic [CNT_W-1:0] i_grants, d_grants;

    always #5 clk = ~clk;

    pmem_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
        .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .i_grants(i_grants), .d_grants(d_grants)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            who;   // 1 = i, 2 = d
        logic          rd;
        logic          wr;
        lc3b_word      addr;
        lc3b_cacheline wdata;
    } grant_t;

    typedef struct {
        int            who;
        lc3b_cacheline rdata;
        int            cnt;   // counter value visible during the resp cycle
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: one owner at a time, a free cycle after every completion,
    // ties resolved by the configured priority rule, counters saturate.
    int m_owner = 0;
    int m_last  = 1;
    int m_cnt[3] = '{0, 0, 0};
    bit m_ip, m_dp;
    int m_win;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner = 0;
            m_last  = 1;
            m_cnt[1] = 0;
            m_cnt[2] = 0;
        end else if (m_owner == 0) begin
            m_ip  = i_read | i_write;
            m_dp  = d_read | d_write;
            m_win = 0;
            if (m_ip && m_dp) begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                m_win = (m_last == 2) ? 1 : 2;
`else
                m_win = 2;
`endif
            end else if (m_dp) begin
                m_win = 2;
            end else if (m_ip) begin
                m_win = 1;
            end
            if (m_win == 1) gq.push_back('{1, i_read & !i_write, i_write, i_address, i_wdata});
            if (m_win == 2) gq.push_back('{2, d_read & !d_write, d_write, d_address, d_wdata});
            m_owner = m_win;
        end else if (pmem_resp) begin
            rq.push_back('{m_owner, pmem_rdata, m_cnt[m_owner]});
            if (m_cnt[m_owner] < CMAX) m_cnt[m_owner]++;
            m_last  = m_owner;
            m_owner = 0;
        end
    end

    // Monitor: compares whatever the DUT presents against the queued expectations.
    initial begin : monitor
        grant_t g, cur;
        resp_t  r;
        logic   act, prev_act;
        prev_act = 1'b0;
        cur = '{0, 1'b0, 1'b0, 16'h0, 128'h0};
        forever begin
            @(negedge clk);
            #1;
            act = pmem_read | pmem_write;
            if (!act) begin
                check("idle_pmem_address", pmem_address, 0);
                check("idle_pmem_wdata", pmem_wdata, 0);
            end else if (!prev_act) begin
                checks++;
                if (gq.size() == 0) begin
                    failures++;
                    $display("FAIL grant_unexpected actual=rd%0b wr%0b addr=%h required=no_grant",
                             pmem_read, pmem_write, pmem_address);
                end else begin
                    g   = gq.pop_front();
                    cur = g;
                    check("grant_read", pmem_read, g.rd);
                    check("grant_write", pmem_write, g.wr);
                    check("grant_address", pmem_address, g.addr);
                    check("grant_wdata", pmem_wdata, g.wdata);
                end
            end else begin
                check("hold_address", pmem_address, cur.addr);
            end
            if (!i_resp) check("i_rdata_zero", i_rdata, 0);
            if (!d_resp) check("d_rdata_zero", d_rdata, 0);
            check("resp_exclusive", i_resp & d_resp, 0);
            if (i_resp || d_resp) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected actual=i%0b d%0b required=no_resp", i_resp, d_resp);
                end else begin
                    r = rq.pop_front();
                    check("resp_who", d_resp ? 2 : 1, r.who);
                    check("resp_rdata", d_resp ? d_rdata : i_rdata, r.rdata);
                    check("resp_grants", d_resp ? d_grants : i_grants, r.cnt);
                end
            end
            prev_act = act;
        end
    end

    // Stimulus
    bit i_busy = 0, d_busy = 0;
    bit s_i, s_d;

    function automatic lc3b_cacheline rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_req(input int who);
        int  k;
        logic rd, wr;
        k  = $urandom_range(0, 3);
        rd = (k != 1);
        wr = (k == 1) || (k == 2);
        if (who == 1) begin
            i_read = rd; i_write = wr; i_address = 16'($urandom); i_wdata = rand_line(); i_busy = 1;
        end else begin
            d_read = rd; d_write = wr; d_address = 16'($urandom); d_wdata = rand_line(); d_busy = 1;
        end
    endtask

    task automatic step(input int p_new, input int p_resp);
        @(negedge clk);
        s_i = i_resp;
        s_d = d_resp;
        @(posedge clk);
        #1;
        if (s_i) begin i_read = 0; i_write = 0; i_busy = 0; end
        if (s_d) begin d_read = 0; d_write = 0; d_busy = 0; end
        if (!i_busy && $urandom_range(0, 99) < p_new) start_req(1);
        if (!d_busy && $urandom_range(0, 99) < p_new) start_req(2);
        pmem_resp  = ($urandom_range(0, 99) < p_resp);
        pmem_rdata = rand_line();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((i_busy || d_busy) && n < 400) begin
            step(0, 30);
            n++;
        end
        checks++;
        if (i_busy || d_busy) begin
            failures++;
            $display("FAIL drain_timeout actual=busy_i%0b_d%0b required=idle", i_busy, d_busy);
        end
        step(0, 0);
    endtask

    initial begin
        rst_n = 1'b1;
        i_read = 0; i_write = 0; i_address = 0; i_wdata = 0;
        d_read = 0; d_write = 0; d_address = 0; d_wdata = 0;
        pmem_resp = 0; pmem_rdata = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_pmem_read", pmem_read, 0);
        check("reset_pmem_write", pmem_write, 0);
        check("reset_i_grants", i_grants, 0);
        check("reset_d_grants", d_grants, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Lone instruction read, memory answers on the third serve cycle.
        @(posedge clk);
        #1 i_read = 1; i_address = 16'h1230; i_wdata = 0; i_busy = 1;
        repeat (3) begin @(posedge clk); #1; end
        pmem_rdata = {16{8'hA5}};
        pmem_resp  = 1;
        @(posedge clk);
        #1 pmem_resp = 0; pmem_rdata = 0; i_read = 0; i_busy = 0;
        @(negedge clk);
        check("first_i_grants", i_grants, 1);

        // Simultaneous requests, repeated to exercise the tie-break rule.
        repeat (4) begin
            @(posedge clk);
            #1 i_read = 1; i_address = 16'($urandom); i_busy = 1;
            d_write = 1; d_address = 16'($urandom); d_wdata = rand_line(); d_busy = 1;
            drain();
        end

        // Read and write together from one requester.
        @(posedge clk);
        #1 d_read = 1; d_write = 1; d_address = 16'($urandom); d_wdata = rand_line(); d_busy = 1;
        drain();

        repeat (1500) step(30, 25);
        drain();

        // Reset while d is being served; a late pmem_resp must be ignored.
        @(posedge clk);
        #1 d_read = 1; d_address = 16'($urandom); d_busy = 1; pmem_resp = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_pmem_read", pmem_read, 0);
        check("async_reset_pmem_write", pmem_write, 0);
        check("async_reset_d_grants", d_grants, 0);
        check("async_reset_i_grants", i_grants, 0);
        @(posedge clk);
        #1 d_read = 0; d_busy = 0;
        @(posedge clk);
        #1 rst_n = 1'b1; pmem_resp = 1; pmem_rdata = rand_line();
        @(negedge clk);
        check("stale_resp_d_resp", d_resp, 0);
        check("stale_resp_pmem_read", pmem_read, 0);
        @(posedge clk);
        #1 pmem_resp = 0;

        repeat (600) step(35, 30);
        drain();

        @(negedge clk);
        #2;
        check("final_i_grants", i_grants, m_cnt[1]);
        check("final_d_grants", d_grants, m_cnt[2]);
        check("grant_queue_empty", gq.size(), 0);
        check("resp_queue_empty", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the per-requester grant counters.
REQ-002 Port clk, input, 1: single clock; all state SHALL change on the rising edge.
REQ-003 Port rst_n, input, 1: reset; asynchronous assert, active-low.
REQ-004 Ports i_read, i_write, input, 1 each: instruction-cache request strobes.
REQ-005 Port i_address, input, lc3b_word: instruction-cache line address.
REQ-006 Port i_wdata, input, lc3b_cacheline: instruction-cache write data.
REQ-007 Port i_resp, output, 1: done pulse to the instruction cache.
REQ-008 Port i_rdata, output, lc3b_cacheline: read data to the instruction cache.
REQ-009 Ports d_read, d_write, d_address, d_wdata, d_resp, d_rdata SHALL mirror REQ-004 to REQ-008 for the data cache.
REQ-010 Ports pmem_read, pmem_write, output, 1 each: physical-memory request strobes.
REQ-011 Port pmem_address, output, lc3b_word: physical-memory address.
REQ-012 Port pmem_wdata, output, lc3b_cacheline: physical-memory write data.
REQ-013 Port pmem_resp, input, 1: physical-memory done pulse.
REQ-014 Port pmem_rdata, input, lc3b_cacheline: physical-memory read data.
REQ-015 Ports i_grants, d_grants, output, CNT_W each: completed-transaction counters.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SERVE_I, SERVE_D.
REQ-017 A requester is "pending" when its read OR write is high; requesters SHALL hold all inputs stable until they receive resp.
REQ-018 IDLE, only i pending: next state SERVE_I.
REQ-019 IDLE, only d pending: next state SERVE_D.
REQ-020 IDLE, neither pending: stay in IDLE.
REQ-021 IDLE, both pending: choose the winner per REQ-033/REQ-034.
REQ-022 In SERVE_x, pmem_read, pmem_write, pmem_address and pmem_wdata SHALL be driven combinationally from requester x.
REQ-023 In IDLE, pmem_read and pmem_write SHALL be 0, pmem_address SHALL be 0 and pmem_wdata SHALL be 0.
REQ-024 In SERVE_x, on pmem_resp=1, x_resp SHALL be 1 in that same cycle, x_rdata SHALL equal pmem_rdata, and the next state SHALL be IDLE.
REQ-025 Consequence of REQ-024: one mandatory IDLE cycle between grants, so a stale request is never re-granted; minimum turnaround = pmem latency + 1 cycle.
REQ-026 The non-granted resp SHALL be 0 at all times; x_rdata SHALL be 0 whenever x_resp=0.
REQ-027 If a requester asserts read and write together, the arbiter SHALL forward only the write (pmem_read=0).
REQ-028 A pmem_resp arriving in IDLE SHALL be ignored: no resp pulse, no state change.
REQ-029 x_grants SHALL increment by 1 on each x_resp pulse and saturate at all-ones (no wrap).
REQ-030 Once granted, a transaction SHALL NOT be preempted by the other requester.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, all outputs 0, both counters 0, priority pointer to favour d.
REQ-032 A transaction in flight at reset SHALL be abandoned; a later pmem_resp lands in IDLE and is ignored per REQ-028.

Configuration
REQ-033 With PMEM_ARB_ROUND_ROBIN_EN defined, a 1-bit last-served register SHALL make simultaneous requests go to the requester not served last; it updates on every resp; reset value = i, so d wins first.
REQ-034 Without PMEM_ARB_ROUND_ROBIN_EN, d SHALL always win simultaneous requests and no last-served register SHALL exist.

Structure
REQ-035 The arb_state_t enum (IDLE, SERVE_I, SERVE_D) SHALL be added to lc3b_types; lc3b_word and lc3b_cacheline SHALL be reused from there.
REQ-036 A single sub-module, sat_counter (parameter W, ports clk, rst_n, inc, count), SHALL be instantiated twice for the grant counters.

Verification
REQ-037 i_read=1 with addr 0x1230 alone; pmem_resp after 3 cycles, pmem_rdata=0xA5..A5 -> pmem_read=1, pmem_address=0x1230; i_resp one cycle, i_rdata=0xA5..A5; i_grants=1.
REQ-038 i_read and d_write both raised in the same cycle, macro off -> d served first, then IDLE one cycle, then i; d_grants=1 and i_grants=1.
REQ-039 Same stimulus repeated 4 times, macro on -> grant order d,i,d,i,d,i,d,i.
REQ-040 rst_n=0 mid SERVE_D, then pmem_resp=1 after release -> pmem strobes drop asynchronously; no d_resp; state IDLE.
REQ-041 CNT_W=2 with 5 i transactions -> i_grants reads 1,2,3,3,3.
REQ-042 d_read=1 and d_write=1 together -> pmem_write=1, pmem_read=0.
